// File: rtl/clock_set_ctrl_pkg.sv
// Shared state encodings, limits and helpers for the clock_set_ctrl time-keeping slice.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    localparam int         SEC_MAX      = 59;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;

    // 24h hours run 00..23; 12h hours run 01..12 and come out of reset at 12
    localparam logic [3:0] HR24_TENS_MAX  = 4'd2;
    localparam logic [3:0] HR24_ONES_MAX  = 4'd3;
    localparam logic [3:0] HR24_TENS_MIN  = 4'd0;
    localparam logic [3:0] HR24_ONES_MIN  = 4'd0;
    localparam logic [3:0] HR24_TENS_INIT = 4'd0;
    localparam logic [3:0] HR24_ONES_INIT = 4'd0;

    localparam logic [3:0] HR12_TENS_MAX  = 4'd1;
    localparam logic [3:0] HR12_ONES_MAX  = 4'd2;
    localparam logic [3:0] HR12_TENS_MIN  = 4'd0;
    localparam logic [3:0] HR12_ONES_MIN  = 4'd1;
    localparam logic [3:0] HR12_TENS_INIT = 4'd1;
    localparam logic [3:0] HR12_ONES_INIT = 4'd2;

    function automatic logic [3:0] blank_mask(input state_t st);
        logic [3:0] mask;
        mask = 4'b0000;
        case (st)
            ST_SET_HR:  mask = 4'b1100;
            ST_SET_MIN: mask = 4'b0011;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter with programmable reset value, wrap-to value and upper limit.
module bcd2_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic [3:0] init_tens,
    input  logic [3:0] init_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] max_tens,
    input  logic [3:0] max_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    logic past_max;

    // Anything at or beyond the limit (including corrupted BCD) wraps to the minimum
    assign past_max = (tens > max_tens) || ((tens == max_tens) && (ones >= max_ones));
    assign wrap     = inc && past_max;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tens <= init_tens;
            ones <= init_ones;
        end else if (inc) begin
            if (past_max) begin
                tens <= min_tens;
                ones <= min_ones;
            end else if (ones >= 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM clock with RUN/SET_HR/SET_MIN editing; define CLOCK_SET_BLINK_EN to add
// the digit_blank output that flashes the field being edited.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter bit FMT_24H = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] thousands,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       colon,
    output logic [1:0] mode
`ifdef CLOCK_SET_BLINK_EN
    ,
    output logic [3:0] digit_blank
`endif
);

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

    localparam logic [3:0] HR_TENS_MAX  = FMT_24H ? HR24_TENS_MAX  : HR12_TENS_MAX;
    localparam logic [3:0] HR_ONES_MAX  = FMT_24H ? HR24_ONES_MAX  : HR12_ONES_MAX;
    localparam logic [3:0] HR_TENS_MIN  = FMT_24H ? HR24_TENS_MIN  : HR12_TENS_MIN;
    localparam logic [3:0] HR_ONES_MIN  = FMT_24H ? HR24_ONES_MIN  : HR12_ONES_MIN;
    localparam logic [3:0] HR_TENS_INIT = FMT_24H ? HR24_TENS_INIT : HR12_TENS_INIT;
    localparam logic [3:0] HR_ONES_INIT = FMT_24H ? HR24_ONES_INIT : HR12_ONES_INIT;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] sec_div, sec_div_nxt;
    logic [5:0]       seconds, seconds_nxt;
    logic             run_active, sec_tick, min_rollover;
    logic             min_inc, hr_inc, min_wrap, hr_wrap_unused;

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // Every transition is taken on btn_mode; the unused code falls back to RUN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (btn_mode) state_nxt = ST_SET_HR;
            ST_SET_HR:  if (btn_mode) state_nxt = ST_SET_MIN;
            ST_SET_MIN: if (btn_mode) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    assign mode = state;

    // A btn_mode in RUN discards any coincident tick, so time freezes on entry to SET_HR
    assign run_active   = (state == ST_RUN) && !btn_mode;
    assign sec_tick     = (state == ST_RUN) && (sec_div == DIV_LAST);
    assign min_rollover = run_active && sec_tick && (seconds >= 6'(SEC_MAX));
    assign min_inc      = min_rollover || ((state == ST_SET_MIN) && btn_inc && !btn_mode);
    assign hr_inc       = (min_rollover && min_wrap) ||
                          ((state == ST_SET_HR) && btn_inc && !btn_mode);

    always_comb begin
        sec_div_nxt = '0;
        seconds_nxt = '0;
        if (run_active) begin
            sec_div_nxt = sec_tick ? '0 : sec_div + DIV_W'(1);
            seconds_nxt = seconds;
            if (sec_tick)
                seconds_nxt = (seconds >= 6'(SEC_MAX)) ? 6'd0 : seconds + 6'd1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            sec_div <= '0;
            seconds <= '0;
            colon   <= 1'b1;
        end else begin
            sec_div <= sec_div_nxt;
            seconds <= seconds_nxt;
            colon   <= (state_nxt != ST_RUN) || (sec_div_nxt < DIV_HALF);
        end
    end

    bcd2_counter u_minutes (
        .clk       (clk_100MHz),
        .reset_n   (reset_n),
        .inc       (min_inc),
        .init_tens (4'd0),
        .init_ones (4'd0),
        .min_tens  (4'd0),
        .min_ones  (4'd0),
        .max_tens  (MIN_TENS_MAX),
        .max_ones  (MIN_ONES_MAX),
        .tens      (tens),
        .ones      (ones),
        .wrap      (min_wrap)
    );

    bcd2_counter u_hours (
        .clk       (clk_100MHz),
        .reset_n   (reset_n),
        .inc       (hr_inc),
        .init_tens (HR_TENS_INIT),
        .init_ones (HR_ONES_INIT),
        .min_tens  (HR_TENS_MIN),
        .min_ones  (HR_ONES_MIN),
        .max_tens  (HR_TENS_MAX),
        .max_ones  (HR_ONES_MAX),
        .tens      (thousands),
        .ones      (hundreds),
        .wrap      (hr_wrap_unused)
    );

`ifdef CLOCK_SET_BLINK_EN
    logic [DIV_W-1:0] blink_cnt, blink_cnt_nxt;
    logic             blink_off, blink_off_nxt;

    // Any edit or state change restarts in the visible phase so the new value shows at once
    always_comb begin
        blink_cnt_nxt = blink_cnt + DIV_W'(1);
        blink_off_nxt = blink_off;
        if (btn_inc || (state_nxt != state)) begin
            blink_cnt_nxt = '0;
            blink_off_nxt = 1'b0;
        end else if (blink_cnt >= DIV_HALF - DIV_W'(1)) begin
            blink_cnt_nxt = '0;
            blink_off_nxt = !blink_off;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_off   <= 1'b0;
            digit_blank <= 4'b0000;
        end else begin
            blink_cnt   <= blink_cnt_nxt;
            blink_off   <= blink_off_nxt;
            digit_blank <= blink_off_nxt ? blank_mask(state_nxt) : 4'b0000;
        end
    end
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with CLK_HZ=10, one 24h and one 12h instance.
module tb_clock_set_ctrl;

    localparam int CLK_HZ = 10;

    logic       clk_100MHz = 1'b0;
    logic       reset_n, btn_mode, btn_inc;
    logic [3:0] th24, hu24, te24, on24, th12, hu12, te12, on12;
    logic       colon24, colon12;
    logic [1:0] mode24, mode12;
`ifdef CLOCK_SET_BLINK_EN
    logic [3:0] blank24, blank12;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .FMT_24H(1'b1)) dut24 (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .thousands  (th24),
        .hundreds   (hu24),
        .tens       (te24),
        .ones       (on24),
        .colon      (colon24),
        .mode       (mode24)
`ifdef CLOCK_SET_BLINK_EN
        ,
        .digit_blank(blank24)
`endif
    );

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .FMT_24H(1'b0)) dut12 (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .thousands  (th12),
        .hundreds   (hu12),
        .tens       (te12),
        .ones       (on12),
        .colon      (colon12),
        .mode       (mode12)
`ifdef CLOCK_SET_BLINK_EN
        ,
        .digit_blank(blank12)
`endif
    );

    typedef struct {
        logic        m;
        logic        i;
        int          reps;
        logic [15:0] exp_time;
        logic [1:0]  exp_mode;
        logic        exp_colon;
    } vec_t;

    vec_t vecs[15];

    // Called at a falling edge; drives the inputs for reps rising edges and returns at a falling edge
    task applyStimulus(input logic m, input logic i, input int reps);
        for (int k = 0; k < reps; k++) begin
            btn_mode = m;
            btn_inc  = i;
            @(negedge clk_100MHz);
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task doReset(input int n);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        reset_n  = 1'b0;
        repeat (n) @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    task checkOutput(input bit use12, input string name, input logic [15:0] exp_time,
                     input logic [1:0] exp_mode, input logic exp_colon);
        logic [15:0] act_time;
        logic [1:0]  act_mode;
        logic        act_colon;
        if (use12) begin
            act_time  = {th12, hu12, te12, on12};
            act_mode  = mode12;
            act_colon = colon12;
        end else begin
            act_time  = {th24, hu24, te24, on24};
            act_mode  = mode24;
            act_colon = colon24;
        end
        checks++;
        if (act_time !== exp_time || act_mode !== exp_mode || act_colon !== exp_colon) begin
            errors++;
            $display("[TB] FAIL %s: got time=%h mode=%b colon=%b, expected time=%h mode=%b colon=%b",
                     name, act_time, act_mode, act_colon, exp_time, exp_mode, exp_colon);
        end
    endtask

`ifdef CLOCK_SET_BLINK_EN
    task checkBlank(input string name, input logic [3:0] exp_blank);
        checks++;
        if (blank24 !== exp_blank) begin
            errors++;
            $display("[TB] FAIL %s: got digit_blank=%b, expected %b", name, blank24, exp_blank);
        end
    endtask
`endif

    initial begin
        bit glitch;

        // 24h edit walk: {btn_mode, btn_inc, cycles, HHMM, mode, colon}
        vecs[0]  = '{1'b1, 1'b0, 1,  16'h0000, 2'b01, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 5,  16'h0500, 2'b01, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 18, 16'h2300, 2'b01, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1,  16'h0000, 2'b01, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 5,  16'h0500, 2'b01, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1,  16'h0500, 2'b10, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 61, 16'h0501, 2'b10, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 58, 16'h0559, 2'b10, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1,  16'h0500, 2'b10, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 3,  16'h0500, 2'b10, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1,  16'h0501, 2'b10, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1,  16'h0501, 2'b00, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4,  16'h0501, 2'b00, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1,  16'h0501, 2'b00, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5,  16'h0501, 2'b00, 1'b1};

        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        @(negedge clk_100MHz);

        // Reset values and colon duty cycle
        doReset(3);
        checkOutput(0, "reset_24h", 16'h0000, 2'b00, 1'b1);
        checkOutput(1, "reset_12h", 16'h1200, 2'b00, 1'b1);
        applyStimulus(0, 0, 4);
        checkOutput(0, "colon_4", 16'h0000, 2'b00, 1'b1);
        applyStimulus(0, 0, 1);
        checkOutput(0, "colon_5", 16'h0000, 2'b00, 1'b0);
        applyStimulus(0, 0, 4);
        checkOutput(0, "colon_9", 16'h0000, 2'b00, 1'b0);
        applyStimulus(0, 0, 1);
        checkOutput(0, "colon_10", 16'h0000, 2'b00, 1'b1);

        doReset(1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(vecs[k].m, vecs[k].i, vecs[k].reps);
            checkOutput(0, $sformatf("vec%0d", k), vecs[k].exp_time, vecs[k].exp_mode, vecs[k].exp_colon);
        end

        // 23:59 -> 00:00 exactly 600 cycles after leaving SET_MIN
        doReset(1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 23);
        checkOutput(0, "set_hr_23", 16'h2300, 2'b01, 1'b1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 59);
        checkOutput(0, "set_min_59", 16'h2359, 2'b10, 1'b1);
        applyStimulus(1, 0, 1);
        checkOutput(0, "exit_to_run", 16'h2359, 2'b00, 1'b1);
        glitch = 1'b0;
        for (int k = 0; k < 599; k++) begin
            applyStimulus(0, 0, 1);
            if ({th24, hu24, te24, on24} !== 16'h2359) glitch = 1'b1;
        end
        checks++;
        if (glitch) begin
            errors++;
            $display("[TB] FAIL hold_2359: time left 23:59 before cycle 600, expected steady 2359");
        end
        applyStimulus(0, 0, 1);
        checkOutput(0, "rollover_600", 16'h0000, 2'b00, 1'b1);

        // btn_mode on the tick that ends second 59: tick dropped, time frozen
        applyStimulus(0, 0, 599);
        checkOutput(0, "pre_tick", 16'h0000, 2'b00, 1'b0);
        applyStimulus(1, 0, 1);
        checkOutput(0, "mode_vs_tick", 16'h0000, 2'b01, 1'b1);
        applyStimulus(1, 0, 2);
        checkOutput(0, "back_to_run", 16'h0000, 2'b00, 1'b1);
        applyStimulus(0, 0, 599);
        checkOutput(0, "full_minute_599", 16'h0000, 2'b00, 1'b0);
        applyStimulus(0, 0, 1);
        checkOutput(0, "full_minute_600", 16'h0001, 2'b00, 1'b1);

        // Reset while editing minutes
        doReset(1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 7);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 33);
        checkOutput(0, "edit_0733", 16'h0733, 2'b10, 1'b1);
        doReset(1);
        checkOutput(0, "reset_mid_edit", 16'h0000, 2'b00, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput(0, "run_ignores_inc", 16'h0000, 2'b00, 1'b1);

        // 12h hour wrap on the second instance
        doReset(1);
        applyStimulus(1, 0, 1);
        checkOutput(1, "h12_set_hr", 16'h1200, 2'b01, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput(1, "h12_12_to_01", 16'h0100, 2'b01, 1'b1);
        applyStimulus(0, 1, 10);
        checkOutput(1, "h12_11", 16'h1100, 2'b01, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput(1, "h12_11_to_12", 16'h1200, 2'b01, 1'b1);
        applyStimulus(0, 1, 11);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 7);
        checkOutput(1, "h12_1107", 16'h1107, 2'b10, 1'b1);
        applyStimulus(1, 0, 2);
        applyStimulus(0, 1, 1);
        checkOutput(1, "h12_1107_to_1207", 16'h1207, 2'b01, 1'b1);

`ifdef CLOCK_SET_BLINK_EN
        // Blink phase in SET_HR / SET_MIN, restarted by btn_inc and state changes
        doReset(1);
        checkBlank("blank_run", 4'b0000);
        applyStimulus(1, 0, 1);
        checkBlank("blank_enter_hr", 4'b0000);
        applyStimulus(0, 0, 4);
        checkBlank("blank_hr_4", 4'b0000);
        applyStimulus(0, 0, 1);
        checkBlank("blank_hr_5", 4'b1100);
        applyStimulus(0, 0, 4);
        checkBlank("blank_hr_9", 4'b1100);
        applyStimulus(0, 0, 1);
        checkBlank("blank_hr_10", 4'b0000);
        applyStimulus(0, 0, 5);
        checkBlank("blank_hr_15", 4'b1100);
        applyStimulus(0, 1, 1);
        checkBlank("blank_hr_inc", 4'b0000);
        checkOutput(0, "blank_hr_value", 16'h0100, 2'b01, 1'b1);
        applyStimulus(1, 0, 1);
        checkBlank("blank_enter_min", 4'b0000);
        applyStimulus(0, 0, 5);
        checkBlank("blank_min_5", 4'b0011);
        applyStimulus(1, 0, 1);
        checkBlank("blank_back_run", 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-keeping and user-set controller for the Basys3 digital clock. Keeps HH:MM (plus hidden seconds) in BCD and runs a RUN/SET_HR/SET_MIN state machine driven by two debounced button pulses. Outputs feed the seven_seg multiplexer directly: thousands=hr_tens, hundreds=hr_ones, tens=min_tens, ones=min_ones.

Parameters:
CLK_HZ, 100_000_000, clock cycles per second; the prescaler period. Benches use 10.
FMT_24H, 1, 1 = 00:00..23:59; 0 = 01:00..12:59 (no AM/PM).

Ports:
clk_100MHz  input  1  system clock
reset_n  input  1  synchronous, active-low reset
btn_mode  input  1  single-cycle pulse, already debounced; advances the FSM
btn_inc  input  1  single-cycle pulse, already debounced; increments the field being edited
thousands  output  4  hour tens BCD, registered
hundreds  output  4  hour ones BCD, registered
tens  output  4  minute tens BCD, registered
ones  output  4  minute ones BCD, registered
colon  output  1  colon/DP enable, registered
mode  output  2  current state code

Behaviour:
- Reset, sampled on the rising clk_100MHz edge while reset_n=0: state RUN, sec_div=0, seconds=0.
- Reset time: 00:00 when FMT_24H=1; 12:00 when FMT_24H=0. colon=1.
- A reset asserted mid-edit abandons the edit and restores reset time.
- Prescaler: sec_div counts 0..CLK_HZ-1 in RUN only. sec_tick is asserted in the cycle where sec_div==CLK_HZ-1, and sec_div wraps to 0 in the same cycle.
- In SET_HR and SET_MIN, sec_div and seconds are held at 0.
- Seconds counter: 0..59, binary. On sec_tick in RUN:
  - seconds 59 -> 0 and the minute increments.
  - Minute 59 -> 00 carries into the hour.
  - Hour wrap: 23 -> 00 (24h); 12 -> 01 (12h). In 12h mode, 11 -> 12 is a normal increment.
- FSM transitions, all taken on btn_mode:
  - RUN -> SET_HR
  - SET_HR -> SET_MIN
  - SET_MIN -> RUN; seconds and sec_div are cleared on exit, so the first minute after setting is a full 60 s.
- mode codes: RUN=2'b00, SET_HR=2'b01, SET_MIN=2'b10. Code 2'b11 is illegal and recovers to RUN on the next edge.
- btn_inc behaviour by state:
  - SET_HR: hour +1 with the wrap rule above; no other field changes.
  - SET_MIN: minute +1, 59 -> 00, no carry into hours.
  - RUN: ignored.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: btn_mode wins, btn_inc is dropped.
  - btn_mode and sec_tick in the same cycle while in RUN: the transition wins, the tick is discarded, and time freezes.
- Latency: a qualifying event is visible on the digit outputs 1 cycle after the sampling edge. Digit outputs are the state registers themselves, with no extra pipeline.
- colon: in RUN, colon = (sec_div < CLK_HZ/2), i.e. 1 Hz at 50% duty. In SET states colon is held at 1.
- BCD invariants: digits never exceed 9, and min_tens never exceeds 5. An illegal BCD value found in a register is corrected on its next increment.

Optional Feature:
- Macro: CLOCK_SET_BLINK_EN.
- When defined:
  - Adds output digit_blank, 4 bits, registered, active-high blank request per digit ([3]=thousands .. [0]=ones).
  - A blink counter (period CLK_HZ/2) toggles a phase bit. SET_HR blanks [3:2] during the off-phase; SET_MIN blanks [1:0]; RUN drives 4'b0000.
  - btn_inc and every state change restart the phase as visible, so an edited value is always shown immediately.
- When undefined: the port and counter are absent, and edited digits are shown steadily.

Decomposition:
- Package clock_ctrl_pkg holds:
  - state encodings ST_RUN, ST_SET_HR, ST_SET_MIN;
  - constants SEC_MAX=59, MIN_TENS_MAX=5;
  - hour wrap limits for 24h and 12h.
- Sub-module bcd2_counter: two-digit BCD up-counter.
  - Inputs: inc, load_min value, max tens/ones limits.
  - Outputs: the two digits and a wrap pulse.
  - Instantiated twice: minutes (00..59) and hours (00..23 or 01..12).
  - The top level owns the FSM, the prescaler, seconds, colon and blink.

Test Plan:
- Reset, CLK_HZ=10, FMT_24H=1: hold reset_n=0 for 3 cycles, release -> digits 0,0,0,0, mode=00, colon=1; after 5 cycles colon=0; after 10 cycles colon=1.
- Rollover: set 23:59 via buttons, return to RUN, run 60*10 cycles -> 00:00 exactly 600 cycles after the exit edge, with no hour glitch.
- 12h wrap, FMT_24H=0: from 12:00, btn_inc in SET_HR -> 01:00; from 11:xx, btn_inc -> 12:xx.
- Edit: btn_mode, then 5x btn_inc -> 05:00; btn_mode, then 61x btn_inc -> 05:01 (wraps, no hour carry); btn_mode -> mode=00, seconds=0.
- Collisions: btn_mode+btn_inc in the same cycle in SET_HR -> mode=10, hour unchanged; btn_mode coinciding with the sec_tick that ends minute 59 -> state SET_HR, minute unchanged.
- Reset mid-edit: in SET_MIN at 07:33, pulse reset_n low for 1 cycle -> 00:00, mode=00. With CLOCK_SET_BLINK_EN: SET_HR -> digit_blank toggles 0000/1100 every 5 cycles (CLK_HZ=10); btn_inc forces 0000.
